crc_check: RTL and testbench

Receive-side CRC checker for the USB packet path, the counterpart of the transmit CRC generator. Sits after NRZI decode and bit unstuffing and takes the serial packet body that follows the PID: data bits plus the trailing CRC field. It runs CRC5 (tokens) or CRC16 (data) over every bit, forwards only the data bits downstream, and strips the CRC field. At end of packet it reports one verdict covering residual match and length legality.

---
 rtl/crc_check.sv | 152 +++++++++++++++
 tb/tb_crc_check.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_check.sv
// Receive-side USB CRC checker: runs CRC5/CRC16 over the unstuffed packet body,
// forwards the data bits with the CRC field stripped, and reports one verdict per packet.
module crc_check #(
    parameter int DATA_CNT_W = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  inb,
    input  logic                  bit_en,
    input  logic                  recving,
    input  logic                  pkttype,
    output logic                  outb,
    output logic                  out_valid,
    output logic                  done,
    output logic                  crc_err,
    output logic                  len_err,
    output logic [DATA_CNT_W-1:0] nbits
);

    localparam logic [4:0]  CRC5_POLY  = 5'b00101;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [4:0]  CRC5_RES   = 5'b01100;
    localparam logic [15:0] CRC16_RES  = 16'h800D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  crctype;
    logic [15:0]           r;
    logic [15:0]           sbuf;
    logic [4:0]            fill;
    logic [DATA_CNT_W-1:0] count;

    logic                  start;
    logic                  in_recv;
    logic                  accept;
    logic                  type_eff;
    logic [4:0]            n_eff;
    logic [15:0]           r_base;
    logic [4:0]            fill_base;
    logic [DATA_CNT_W-1:0] cnt_base;
    logic                  emit;
    logic [15:0]           r_nxt;
    logic [4:0]            fill_nxt;
    logic [DATA_CNT_W-1:0] count_nxt;
    logic                  chk_cycle;

    // One LFSR step; in CRC5 mode only the low five bits carry state.
    function automatic logic [15:0] crc_step(input logic [15:0] cur, input logic b,
                                             input logic is16);
        logic        fb;
        logic [15:0] nxt;
        if (is16) begin
            fb  = b ^ cur[15];
            nxt = {cur[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end else begin
            fb  = b ^ cur[4];
            nxt = {11'b0, cur[3:0], 1'b0} ^ (fb ? {11'b0, CRC5_POLY} : 16'h0000);
        end
        return nxt;
    endfunction

    function automatic logic [DATA_CNT_W-1:0] sat_inc(input logic [DATA_CNT_W-1:0] c);
        return (c == {DATA_CNT_W{1'b1}}) ? c : c + DATA_CNT_W'(1);
    endfunction

    function automatic logic residual_bad(input logic [15:0] cur, input logic is16);
        return is16 ? (cur != CRC16_RES) : (cur[4:0] != CRC5_RES);
    endfunction

    function automatic logic length_bad(input logic [DATA_CNT_W-1:0] c, input logic is16);
        if (is16)
            return (c < DATA_CNT_W'(16)) || (c[2:0] != 3'd0);
        else
            return c != DATA_CNT_W'(16);
    endfunction

    // Data-bit count excludes the CRC field; short packets clamp to zero.
    function automatic logic [DATA_CNT_W-1:0] data_bits(input logic [DATA_CNT_W-1:0] c,
                                                        input logic is16);
        logic [DATA_CNT_W-1:0] n;
        n = is16 ? DATA_CNT_W'(16) : DATA_CNT_W'(5);
        return (c < n) ? '0 : c - n;
    endfunction

    always_comb begin
        start     = recving && !clear && (state == IDLE || state == CHECK);
        in_recv   = recving && !clear && (state == RECV);
        accept    = bit_en && (start || in_recv);
        type_eff  = start ? pkttype : crctype;
        n_eff     = type_eff ? 5'd16 : 5'd5;
        r_base    = start ? 16'hFFFF : r;
        fill_base = start ? 5'd0 : fill;
        cnt_base  = start ? '0 : count;
        emit      = accept && (fill_base == n_eff);
        r_nxt     = accept ? crc_step(r_base, inb, type_eff) : r_base;
        fill_nxt  = (accept && !emit) ? fill_base + 5'd1 : fill_base;
        count_nxt = accept ? sat_inc(cnt_base) : cnt_base;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RECV;
            RECV:    if (!recving) state_nxt = CHECK;
            CHECK:   state_nxt = start ? RECV : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            crctype   <= 1'b0;
            r         <= 16'hFFFF;
            fill      <= 5'd0;
            count     <= '0;
            outb      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            if (start) crctype <= pkttype;
            r         <= r_nxt;
            fill      <= fill_nxt;
            count     <= count_nxt;
            out_valid <= emit;
            outb      <= emit ? (type_eff ? sbuf[15] : sbuf[4]) : 1'b0;
        end
    end

    // Strip buffer contents are only meaningful below fill, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) sbuf <= {sbuf[14:0], inb};
    end

    // Verdict is qualified combinationally so a reset or abort in CHECK hides it.
    always_comb begin
        chk_cycle = (state == CHECK) && !rst && !clear;
        done      = chk_cycle;
        crc_err   = chk_cycle && residual_bad(r, crctype);
        len_err   = chk_cycle && length_bad(count, crctype);
        nbits     = chk_cycle ? data_bits(count, crctype) : '0;
    end

endmodule

// File: tb/tb_crc_check.sv
// Randomized self-checking bench for crc_check against a queue-based packet model.
module tb_crc_check;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         inb = 1'b0;
    logic         bit_en = 1'b0;
    logic         recving = 1'b0;
    logic         pkttype = 1'b0;
    logic         outb;
    logic         out_valid;
    logic         done;
    logic         crc_err;
    logic         len_err;
    logic [W-1:0] nbits;

    int           n_cmp = 0;
    int           n_bad = 0;

    bit           pkt[$];
    bit           got_bits[$];
    bit           exp_bits[$];
    logic [15:0]  got_v[$];
    logic [15:0]  exp_v[$];

    crc_check #(.DATA_CNT_W(W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .inb(inb), .bit_en(bit_en),
        .recving(recving), .pkttype(pkttype), .outb(outb), .out_valid(out_valid),
        .done(done), .crc_err(crc_err), .len_err(len_err), .nbits(nbits)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) got_bits.push_back(outb);
        if (done === 1'b1) got_v.push_back({crc_err, len_err, nbits});
        else chk_eq("verdict_quiet", {16'h0, crc_err, len_err, nbits}, 32'h0);
    end

    // Reference: CRC of pkt[0..upto-1] from the polynomial rule, all-ones seed.
    function automatic logic [15:0] crc_run(input bit typ, input int upto);
        logic [15:0] poly, mask, rr;
        int          n;
        bit          fb;
        poly = typ ? 16'h8005 : 16'h0005;
        mask = typ ? 16'hFFFF : 16'h001F;
        n    = typ ? 16 : 5;
        rr   = mask;
        for (int i = 0; i < upto; i++) begin
            fb = pkt[i] ^ rr[n-1];
            rr = ((rr << 1) & mask) ^ (fb ? poly : 16'h0);
        end
        return rr;
    endfunction

    // Append the inverted remainder, most significant term first.
    task automatic add_crc(input bit typ);
        logic [15:0] rr;
        int          n;
        n  = typ ? 16 : 5;
        rr = crc_run(typ, pkt.size());
        for (int j = n - 1; j >= 0; j--) pkt.push_back(~rr[j]);
    endtask

    task automatic expect_pkt(input bit typ);
        int          n, cnt, nb;
        logic [15:0] rr;
        bit          cbad, lbad;
        n    = typ ? 16 : 5;
        cnt  = pkt.size();
        rr   = crc_run(typ, cnt);
        cbad = typ ? (rr != 16'h800D) : (rr[4:0] != 5'b01100);
        lbad = typ ? (cnt < 16 || ((cnt - 16) % 8) != 0) : (cnt != 16);
        nb   = (cnt < n) ? 0 : cnt - n;
        exp_v.push_back({cbad, lbad, W'(nb)});
        for (int i = 0; i < cnt - n; i++) exp_bits.push_back(pkt[i]);
    endtask

    task automatic cyc(input logic rv, input logic en, input logic b, input logic clr,
                       input logic rs);
        recving = rv; bit_en = en; inb = b; clear = clr; rst = rs;
        @(posedge clk);
        #1;
    endtask

    // stall: 0 none, 1 idle cycle before every bit, 2 random idle cycles
    task automatic send_bits(input bit typ, input int stall);
        pkttype = typ;
        for (int i = 0; i < pkt.size(); i++) begin
            if (stall == 1 || (stall == 2 && $urandom_range(0, 2) == 0))
                cyc(1'b1, 1'b0, 1'($urandom), 1'b0, 1'b0);
            cyc(1'b1, 1'b1, pkt[i], 1'b0, 1'b0);
            pkttype = 1'($urandom);
        end
    endtask

    task automatic end_pkt();
        cyc(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic compare(input string tag);
        chk_eq({tag, "_fwd_cnt"}, got_bits.size(), exp_bits.size());
        for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++)
            chk_eq({tag, "_fwd_bit"}, got_bits[i], exp_bits[i]);
        chk_eq({tag, "_done_cnt"}, got_v.size(), exp_v.size());
        for (int i = 0; i < got_v.size() && i < exp_v.size(); i++)
            chk_eq({tag, "_verdict"}, got_v[i], exp_v[i]);
        got_bits.delete(); exp_bits.delete(); got_v.delete(); exp_v.delete();
    endtask

    task automatic rand_data(input int len);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(1'($urandom));
    endtask

    initial begin
        bit typ;
        int len, gap;

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_eq("rst_outb", outb, 0);
        chk_eq("rst_out_valid", out_valid, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_nbits", nbits, 0);
        idle(2);

        // Good SETUP token: 11 zero bits, CRC5 field 0,1,0,0,0
        pkt.delete();
        for (int i = 0; i < 11; i++) pkt.push_back(1'b0);
        add_crc(1'b0);
        chk_eq("tok_crc_field", {pkt[11], pkt[12], pkt[13], pkt[14], pkt[15]}, 5'b01000);
        expect_pkt(1'b0);
        chk_eq("tok_exp_verdict", exp_v[0], {2'b00, W'(11)});
        send_bits(1'b0, 0); end_pkt(); idle(3);
        compare("token");

        // Zero-length DATA packet
        pkt.delete();
        for (int i = 0; i < 16; i++) pkt.push_back(1'b0);
        expect_pkt(1'b1);
        chk_eq("zlp_exp_verdict", exp_v[0], 16'h0);
        send_bits(1'b1, 0); end_pkt(); idle(3);
        compare("zlp");

        // Corrupted token, then the same with stalls between bits
        pkt.delete();
        for (int i = 0; i < 11; i++) pkt.push_back(1'b0);
        add_crc(1'b0);
        pkt[3] = ~pkt[3];
        expect_pkt(1'b0);
        chk_eq("corrupt_exp_crc", exp_v[0][15], 1);
        send_bits(1'b0, 0); end_pkt(); idle(3);
        compare("corrupt");
        expect_pkt(1'b0);
        send_bits(1'b0, 1); end_pkt(); idle(3);
        compare("corrupt_stall");

        // CRC16 with one data bit dropped, then a 4-bit CRC5 packet
        rand_data(8); add_crc(1'b1); pkt.delete(2);
        expect_pkt(1'b1);
        send_bits(1'b1, 0); end_pkt(); idle(3);
        compare("drop_bit");
        rand_data(4);
        expect_pkt(1'b0);
        send_bits(1'b0, 2); end_pkt(); idle(3);
        compare("short5");

        // Abort after 9 bits: only bits 0..3 had left the strip buffer
        rand_data(9);
        for (int i = 0; i < 4; i++) exp_bits.push_back(pkt[i]);
        send_bits(1'b0, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);
        compare("abort");
        rand_data(11); add_crc(1'b0); expect_pkt(1'b0);
        send_bits(1'b0, 0); end_pkt(); idle(3);
        compare("after_abort");

        // Reset landing on the CHECK cycle swallows the verdict
        rand_data(11); add_crc(1'b0); expect_pkt(1'b0);
        void'(exp_v.pop_back());
        send_bits(1'b0, 0); end_pkt();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_eq("rst_check_valid", out_valid, 0);
        idle(2);
        compare("rst_in_check");

        // Back-to-back: second packet starts in the CHECK cycle
        rand_data(11); add_crc(1'b0); expect_pkt(1'b0);
        send_bits(1'b0, 0); end_pkt();
        pkt.delete();
        for (int i = 0; i < 16; i++) pkt.push_back(1'b0);
        add_crc(1'b1); expect_pkt(1'b1);
        chk_eq("b2b_exp_verdict", exp_v[1], {2'b00, W'(16)});
        send_bits(1'b1, 0); end_pkt(); idle(3);
        compare("b2b");

        // Random packets, gaps, stalls and corruption
        for (int it = 0; it < 40; it++) begin
            typ = 1'($urandom);
            if (typ) len = 8 * $urandom_range(0, 6);
            else     len = 11;
            if ($urandom_range(0, 4) == 0) len = (len == 0) ? 1 : len + ($urandom_range(0, 1) ? 1 : -1);
            rand_data(len); add_crc(typ);
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = $urandom_range(0, pkt.size() - 1);
                pkt[k] = ~pkt[k];
            end
            expect_pkt(typ);
            send_bits(typ, $urandom_range(0, 2));
            end_pkt();
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                idle(gap);
                compare("rand");
            end
        end
        idle(3);
        compare("rand_tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
